// File: rtl/ifetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_unit_if
// Brief   : UART upgrade port that reloads the fetch unit's instruction ROM.
// Revision: 1.0
// ============================================================================
interface ifetch_unit_if #(
    parameter int ROM_AW = 14
);
    logic              upg_rst_i;
    logic              upg_done_i;
    logic              upg_wen_i;
    logic [ROM_AW:0]   upg_adr_i;
    logic [31:0]       upg_dat_i;

    modport master (
        output upg_rst_i,
        output upg_done_i,
        output upg_wen_i,
        output upg_adr_i,
        output upg_dat_i
    );

    modport slave (
        input  upg_rst_i,
        input  upg_done_i,
        input  upg_wen_i,
        input  upg_adr_i,
        input  upg_dat_i
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_unit
// Brief   : PC/next-PC logic with an in-place reloadable synchronous ROM.
// Revision: 1.0
// ============================================================================
module ifetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ROM_AW   = 14,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
    input  wire logic            clk,
    input  wire logic            rstn,
    input  wire logic            stall,
    input  wire logic            branch,
    input  wire logic            jump,
    input  wire logic            jalr,
    input  wire logic [XLEN-1:0] imm32,
    input  wire logic [XLEN-1:0] alu_result,
    ifetch_unit_if.slave         upg,
    output logic [31:0]          inst,
    output logic                 inst_valid,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      pc4,
    output logic                 fault,
    output logic [XLEN-1:0]      fault_pc
);

    localparam logic [XLEN-1:0] C_FOUR = XLEN'(4);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    fault_pc_q, fault_pc_d;
    logic               inst_valid_q, inst_valid_d;
    logic               fault_q, fault_d;
    logic               boot_arm_q;
    logic [XLEN-1:0]    target;
    logic [ROM_AW-1:0]  rd_addr;
    logic               rom_we;
    logic               load_mode;
    logic [31:0]        rom_q;
    logic [31:0]        mem [0:(1<<ROM_AW)-1];
    logic               unused_bits;

    assign load_mode   = ~upg.upg_rst_i & ~upg.upg_done_i;
    assign pc4         = pc_q + C_FOUR;
    assign unused_bits = alu_result[0];

    always_comb begin
        target = pc4;
        if (branch | jump) begin
            target = pc_q + imm32;
        end else if (jalr) begin
            target = {alu_result[XLEN-1:1], 1'b0};
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        fault_d      = fault_q;
        fault_pc_d   = fault_pc_q;
        rd_addr      = pc_q[ROM_AW+1:2];
        rom_we       = 1'b0;
        case (state_q)
            S_BOOT: begin
                rd_addr      = RESET_PC[ROM_AW+1:2];
                pc_d         = RESET_PC;
                inst_valid_d = 1'b0;
                // Hold one extra edge after reset release so rstn deassertion settles first.
                if (boot_arm_q) begin
                    if (load_mode) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d      = S_FETCH;
                        inst_valid_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (load_mode) begin
                    state_d      = S_LOAD;
                    inst_valid_d = 1'b0;
                end else if (!stall) begin
                    if (target[1]) begin
                        state_d      = S_FAULT;
                        inst_valid_d = 1'b0;
                        fault_d      = 1'b1;
                        fault_pc_d   = target;
                    end else begin
                        pc_d         = target;
                        rd_addr      = target[ROM_AW+1:2];
                        inst_valid_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                pc_d         = RESET_PC;
                inst_valid_d = 1'b0;
                rom_we       = upg.upg_wen_i & ~upg.upg_adr_i[ROM_AW];
                if (!load_mode) begin
                    state_d = S_BOOT;
                end
            end
            S_FAULT: begin
                inst_valid_d = 1'b0;
                if (load_mode) begin
                    state_d = S_LOAD;
                    fault_d = 1'b0;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_pc_q   <= '0;
            boot_arm_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
            fault_pc_q   <= fault_pc_d;
            boot_arm_q   <= 1'b1;
        end
    end

    // Single-port ROM: writes only while loading, otherwise one-cycle read.
    always_ff @(posedge clk) begin
        if (rom_we) begin
            mem[upg.upg_adr_i[ROM_AW-1:0]] <= upg.upg_dat_i;
        end else begin
            rom_q <= mem[rd_addr];
        end
    end

    assign inst       = inst_valid_q ? rom_q : NOP_INST;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign fault      = fault_q;
    assign fault_pc   = fault_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifetch_unit
// Brief   : Directed plus randomized bench for ifetch_unit against a fetch model.
// Revision: 1.0
// ============================================================================
module tb_ifetch_unit;

    localparam int          AW     = 6;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall, branch, jump, jalr;
    logic [31:0] imm32, alu_result;
    logic [31:0] inst, pc, pc4, fault_pc;
    logic        inst_valid, fault;

    ifetch_unit_if #(.ROM_AW(AW)) upg_if ();

    ifetch_unit #(
        .XLEN     (32),
        .ROM_AW   (AW),
        .RESET_PC (RST_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .stall      (stall),
        .branch     (branch),
        .jump       (jump),
        .jalr       (jalr),
        .imm32      (imm32),
        .alu_result (alu_result),
        .upg        (upg_if),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc4        (pc4),
        .fault      (fault),
        .fault_pc   (fault_pc)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    string       phase = "init";

    // Reference model: architectural view of the fetch unit.
    logic [31:0] mem_m [64];
    logic [31:0] pc_m, inst_m, fault_pc_m;
    bit          valid_m, fault_m, loading_m, halted_m;
    int          boot_left_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pc_m        = RST_PC;
        valid_m     = 1'b0;
        fault_m     = 1'b0;
        fault_pc_m  = '0;
        loading_m   = 1'b0;
        halted_m    = 1'b0;
        boot_left_m = 2;
    endtask

    task automatic model_edge();
        bit          lm;
        logic [31:0] tgt;
        lm = !upg_if.upg_rst_i && !upg_if.upg_done_i;
        if (!rstn) begin
            model_reset();
        end else if (loading_m) begin
            if (upg_if.upg_wen_i && !upg_if.upg_adr_i[AW])
                mem_m[upg_if.upg_adr_i[AW-1:0]] = upg_if.upg_dat_i;
            pc_m    = RST_PC;
            valid_m = 1'b0;
            if (!lm) begin
                loading_m   = 1'b0;
                boot_left_m = 1;
            end
        end else if (halted_m) begin
            if (lm) begin
                halted_m  = 1'b0;
                fault_m   = 1'b0;
                loading_m = 1'b1;
            end
        end else if (boot_left_m == 2) begin
            boot_left_m = 1;
        end else if (boot_left_m == 1) begin
            boot_left_m = 0;
            pc_m        = RST_PC;
            if (lm) begin
                loading_m = 1'b1;
            end else begin
                valid_m = 1'b1;
                inst_m  = mem_m[int'((RST_PC >> 2) & 32'h3F)];
            end
        end else if (lm) begin
            loading_m = 1'b1;
            valid_m   = 1'b0;
        end else if (!stall) begin
            if (branch || jump)  tgt = pc_m + imm32;
            else if (jalr)       tgt = alu_result & 32'hFFFF_FFFE;
            else                 tgt = pc_m + 32'd4;
            if (tgt[1]) begin
                halted_m   = 1'b1;
                fault_m    = 1'b1;
                fault_pc_m = tgt;
                valid_m    = 1'b0;
            end else begin
                pc_m    = tgt;
                valid_m = 1'b1;
                inst_m  = mem_m[tgt[AW+1:2]];
            end
        end
    endtask

    task automatic compare_all();
        check("pc",         pc,                    pc_m);
        check("pc4",        pc4,                   pc_m + 32'd4);
        check("inst_valid", {31'b0, inst_valid},   {31'b0, valid_m});
        check("inst",       inst,                  valid_m ? inst_m : NOP);
        check("fault",      {31'b0, fault},        {31'b0, fault_m});
        check("fault_pc",   fault_pc,              fault_pc_m);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        stall = 0; branch = 0; jump = 0; jalr = 0; imm32 = '0; alu_result = '0;
    endtask

    task automatic wr(input logic [AW:0] a, input logic [31:0] d);
        upg_if.upg_wen_i = 1'b1;
        upg_if.upg_adr_i = a;
        upg_if.upg_dat_i = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int load_left;
        phase = "reset";
        rstn = 1'b0;
        idle();
        upg_if.upg_rst_i  = 1'b0;
        upg_if.upg_done_i = 1'b0;
        upg_if.upg_wen_i  = 1'b0;
        upg_if.upg_adr_i  = '0;
        upg_if.upg_dat_i  = '0;
        model_reset();
        #1 compare_all();
        tick();
        tick();
        rstn = 1'b1;

        // Reset releases straight into an upgrade that fills the whole ROM.
        phase = "initial_load";
        tick();
        tick();
        for (int i = 0; i < 64; i++) begin
            case (i)
                0:       wr(7'(i), 32'hAAAA_0000);
                1:       wr(7'(i), 32'hBBBB_0001);
                2:       wr(7'(i), 32'hCCCC_0002);
                3:       wr(7'(i), 32'hDDDD_0003);
                default: wr(7'(i), $urandom);
            endcase
            tick();
        end
        upg_if.upg_wen_i = 1'b0;
        upg_if.upg_rst_i = 1'b1;
        tick();

        phase = "sequential";
        tick();
        check("plan_inst_a", inst, 32'hAAAA_0000);
        tick();
        tick();
        check("plan_pc_8", pc, 32'h8);
        check("plan_inst_c", inst, 32'hCCCC_0002);

        phase = "redirect";
        branch = 1; imm32 = -32'sd8;
        tick();
        check("branch_pc", pc, 32'h0);
        branch = 0; jalr = 1; alu_result = 32'h11;
        tick();
        check("jalr_pc", pc, 32'h10);
        alu_result = 32'h4;
        tick();

        phase = "stall";
        jalr = 0; stall = 1; jump = 1; imm32 = 32'd8;
        repeat (3) begin
            tick();
            check("stall_inst_b", inst, 32'hBBBB_0001);
        end
        stall = 0; jump = 0;
        tick();
        check("post_stall_pc", pc, 32'h8);

        phase = "fault";
        jalr = 1; alu_result = 32'h0;
        tick();
        jalr = 0; jump = 1; imm32 = 32'd2;
        tick();
        check("fault_pc_2", fault_pc, 32'h2);
        jump = 0;
        repeat (10) tick();
        check("fault_pc_frozen", pc, 32'h0);

        phase = "reload";
        upg_if.upg_rst_i = 1'b0;
        tick();
        wr(7'h00, 32'hDEAD_BEEF);
        tick();
        wr(7'h40, 32'h1234_5678);
        tick();
        upg_if.upg_wen_i  = 1'b0;
        upg_if.upg_done_i = 1'b1;
        tick();
        upg_if.upg_done_i = 1'b0;
        upg_if.upg_rst_i  = 1'b1;
        tick();
        check("reload_inst", inst, 32'hDEAD_BEEF);
        check("reload_fault", {31'b0, fault}, 32'h0);

        phase = "wrap";
        jalr = 1; alu_result = 32'hFFFF_FFFC;
        tick();
        jalr = 0;
        tick();
        check("wrap_pc", pc, 32'h0);
        check("wrap_inst", inst, 32'hDEAD_BEEF);

        phase = "reset_mid_load";
        upg_if.upg_rst_i = 1'b0;
        tick();
        wr(7'h01, 32'hCAFE_F00D);
        tick();
        upg_if.upg_wen_i = 1'b0;
        #2 rstn = 1'b0;
        #1 model_reset();
        compare_all();
        upg_if.upg_rst_i = 1'b1;
        tick();
        rstn = 1'b1;
        tick();
        check("edge1_not_valid", {31'b0, inst_valid}, 32'h0);
        tick();
        check("edge2_valid", {31'b0, inst_valid}, 32'h1);
        jalr = 1; alu_result = 32'h4;
        tick();
        check("retained_write", inst, 32'hCAFE_F00D);

        phase = "random";
        load_left = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            stall  = ($urandom_range(0, 99) < 15);
            branch = ($urandom_range(0, 99) < 15);
            jump   = ($urandom_range(0, 99) < 5);
            jalr   = ($urandom_range(0, 99) < 10);
            imm32  = 32'((int'($urandom_range(0, 32)) - 16) * 4);
            if ($urandom_range(0, 99) < 4) imm32 = imm32 + 32'd2;
            alu_result = $urandom & 32'hFFFF_FFFD;
            if ($urandom_range(0, 99) < 4) alu_result = alu_result | 32'h2;
            if (load_left == 0 && (halted_m || $urandom_range(0, 99) < 2))
                load_left = $urandom_range(2, 6);
            upg_if.upg_wen_i = 1'($urandom_range(0, 1));
            upg_if.upg_adr_i = 7'($urandom);
            upg_if.upg_dat_i = $urandom;
            if (load_left > 0) begin
                load_left--;
                upg_if.upg_rst_i  = 1'b0;
                upg_if.upg_done_i = 1'b0;
            end else if ($urandom_range(0, 1) == 0) begin
                upg_if.upg_rst_i  = 1'b1;
                upg_if.upg_done_i = 1'b0;
            end else begin
                upg_if.upg_rst_i  = 1'b0;
                upg_if.upg_done_i = 1'b1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

Parametrised instruction-fetch unit for the single-cycle core. It holds the PC and computes the next PC from branch, jump and jalr controls. It owns an internal synchronous instruction ROM that the UART upgrade path can reload in place. Compared with the previous fetch stage it adds a configurable width, depth and reset vector, plus a stall input, an explicit boot/load/fault state machine, jalr LSB clearing and misaligned-target detection. It sits between the UART programmer and the decoder.

## Interface
- XLEN, 32, datapath and PC width
- ROM_AW, 14, ROM word-address bits; the ROM holds 2^ROM_AW words
- RESET_PC, 32'h0000_0000, PC after reset (word-aligned)
- NOP_INST, 32'h0000_0013, value driven on `inst` when not valid
- clk  in  1  core clock; all state changes on posedge
- rstn  in  1  reset, asynchronous, active-low
- stall  in  1  hold PC and inst
- branch  in  1  taken conditional branch: target = pc + imm32
- jump  in  1  jal: target = pc + imm32
- jalr  in  1  target = {alu_result[XLEN-1:1], 1'b0}
- imm32  in  XLEN  PC-relative offset, sign-extended
- alu_result  in  XLEN  jalr base+offset
- upg_rst_i  in  1  high = upgrade inactive
- upg_done_i  in  1  upgrade finished
- upg_wen_i  in  1  ROM write strobe, synchronous to clk
- upg_adr_i  in  ROM_AW+1  bit ROM_AW selects data memory, so ROM write is ignored when it is set
- upg_dat_i  in  32  write data
- inst  out  32  instruction at pc
- inst_valid  out  1  inst corresponds to pc and may be executed
- pc  out  XLEN  current PC
- pc4  out  XLEN  pc + 4, combinational
- fault  out  1  sticky misaligned-target flag
- fault_pc  out  XLEN  offending target address

## Operation
- load_mode = ~upg_rst_i & ~upg_done_i.
- States:
  - BOOT: issue ROM read of RESET_PC.
  - FETCH: normal operation.
  - LOAD: upgrade in progress.
  - FAULT: halted.
- Reset: state = BOOT, pc = RESET_PC, inst_valid = 0, fault = 0, fault_pc = 0. `inst` shows NOP_INST whenever inst_valid = 0.
- BOOT -> LOAD if load_mode, else -> FETCH.
- FETCH -> LOAD on load_mode, which has the highest priority.
- FETCH, no stall, no load_mode: compute target.
  - Target priority: (branch|jump) > jalr > pc+4.
  - target[1] = 1 -> FAULT; pc holds; fault = 1; fault_pc = target.
  - Otherwise pc <= target and the ROM reads target[ROM_AW+1:2].
- FETCH with stall: pc holds, the ROM re-reads pc, inst and inst_valid are unchanged, and controls are ignored.
- LOAD:
  - ROM port is write-only: on upg_wen_i & ~upg_adr_i[ROM_AW], write mem[upg_adr_i[ROM_AW-1:0]] <= upg_dat_i.
  - inst_valid = 0, pc <= RESET_PC.
  - On load_mode falling -> BOOT.
- FAULT: inst_valid = 0, pc frozen. Only rstn or load_mode leaves it; load_mode -> LOAD and clears fault.
- Arithmetic is modulo 2^XLEN: pc + imm32 and pc + 4 wrap silently. ROM address bits above ROM_AW+1 are ignored, so addresses alias.

## Timing
- ROM is synchronous read with one-cycle latency. The address presented at an edge becomes the inst after that edge, so inst and pc stay aligned.
- First inst_valid = 1 occurs on the second posedge after rstn deasserts (BOOT then FETCH).
- FETCH throughput is one instruction per cycle; the redirect penalty is zero.
- inst_valid drops in the same edge that enters LOAD or FAULT.
- After LOAD exits, BOOT takes 1 cycle, then the instruction at RESET_PC is valid.
- An asynchronous rstn mid-LOAD aborts the load; ROM contents already written are retained.
- Simultaneous branch and jalr: branch wins. Stall together with a redirect: the redirect is lost, and the datapath re-presents it.

## Test plan
- Reset release, ROM[0..3]=A,B,C,D, no controls -> pc 0,4,8,C with inst A,B,C,D; inst_valid rises on 2nd edge.
- At pc=8 assert branch with imm32=-8 -> next pc=0, inst=A; then jalr with alu_result=0x11 -> pc=0x10.
- stall held 3 cycles at pc=4 with jump asserted -> pc=4 and inst=B throughout, then normal on release.
- jump with imm32=2 at pc=0 -> fault=1, fault_pc=2, inst_valid=0, pc frozen at 0 for 10 cycles.
- load_mode with writes ROM[0]=0xDEADBEEF, a write with upg_adr_i[ROM_AW]=1 ignored, then done -> BOOT, inst=0xDEADBEEF at pc=0; fault cleared.
- Wrap test, XLEN=32: pc=0xFFFF_FFFC, no controls -> pc=0, ROM address 0.
